// File: rtl/input_capture_pkg.sv
// Shared definitions for the input capture front end and its display partner:
// FSM state encoding and default prescaler/debounce constants.
package input_capture_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        WAIT_RELEASE = 2'd2,
        VALID        = 2'd3
    } state_e;

    localparam int DEFAULT_DIV      = 1024;
    localparam int DEFAULT_DB_TICKS = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_capture_debounce.sv
// Button conditioner: 2-flop synchronizer, tick-driven stable counter and a
// one-cycle pulse on the debounced rising edge. The sample tick comes from outside.
module input_capture_debounce
    import input_capture_pkg::*;
#(
    parameter int DB_TICKS = DEFAULT_DB_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = cnt_width(DB_TICKS);

    logic          meta_q;
    logic          sync_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A level change is accepted only after DB_TICKS consecutive disagreeing ticks.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (tick_i) begin
            if (sync_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DB_TICKS - 1)) begin
                cnt_d   = '0;
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= raw_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/input_capture.sv
// User-input front end: prompts via inp_take, captures the switches on a debounced
// enter press and hands them over with a valid/ack handshake. Optional: BTN_CANCEL_EN.
module input_capture
    import input_capture_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIV      = DEFAULT_DIV,
    parameter int DB_TICKS = DEFAULT_DB_TICKS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_enter,
    input  logic              inp_req,
    output logic              inp_take,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ack
`ifdef BTN_CANCEL_EN
    ,
    input  logic              btn_cancel,
    output logic              cancelled
`endif
);

    localparam int TW = cnt_width(DIV);

    logic [TW-1:0]     tick_q;
    logic [TW-1:0]     tick_d;
    logic              tick;
    logic [DATA_W-1:0] sw_meta_q;
    logic [DATA_W-1:0] sw_sync_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    state_e            state_q;
    state_e            state_d;
    logic              enter_level;
    logic              enter_press;
    logic              cancel_hit;

    assign tick   = (tick_q == TW'(DIV - 1));
    assign tick_d = tick ? '0 : tick_q + 1'b1;

    input_capture_debounce #(.DB_TICKS(DB_TICKS)) u_enter (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_i  (tick),
        .raw_i   (btn_enter),
        .level_o (enter_level),
        .press_o (enter_press)
    );

`ifdef BTN_CANCEL_EN
    logic cancel_level;
    logic cancel_press;
    logic cancelled_q;

    input_capture_debounce #(.DB_TICKS(DB_TICKS)) u_cancel (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_i  (tick),
        .raw_i   (btn_cancel),
        .level_o (cancel_level),
        .press_o (cancel_press)
    );

    assign cancel_hit = cancel_press & cancel_level &
                        ((state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE));

    always_ff @(posedge clk) begin
        if (!rst_n) cancelled_q <= 1'b0;
        else        cancelled_q <= cancel_hit;
    end

    assign cancelled = cancelled_q;
`else
    assign cancel_hit = 1'b0;
`endif

    // Only a fresh debounced rising edge inside WAIT_PRESS captures; aborts win over it.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (inp_req) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (cancel_hit || !inp_req) begin
                    state_d = IDLE;
                end else if (enter_press) begin
                    data_d  = sw_sync_q;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (cancel_hit || !inp_req) state_d = IDLE;
                else if (!enter_level)      state_d = VALID;
            end
            VALID: begin
                if (data_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            data_q    <= '0;
            state_q   <= IDLE;
        end else begin
            tick_q    <= tick_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            data_q    <= data_d;
            state_q   <= state_d;
        end
    end

    assign inp_take   = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
    assign data_valid = (state_q == VALID);
    assign data       = data_q;

endmodule
